reward_decider_pipe: RTL
========================

# reward_decider_pipe

Parametrised reward decider for the Q-learning traffic-light agent. It takes the chosen action and the greedy (`Amax`) and worst (`Amin`) actions for a state, selects one of three signed reward levels, and emits it through a 2-stage valid/ready pipeline. It sits between the Q-table argmax/argmin unit and the Q-update datapath. It also keeps per-episode statistics (saturating reward sum, step count, greedy-hit count) for the host.

## Interface
- `DW`, 32: reward width, signed two's complement.
- `NA`, 4: number of actions, ≥2.
- `AW`, `$clog2(NA)`: action index width, derived.
- `SW`, 40: accumulator width, must be ≥ DW.
- `CW`, 24: step/hit counter width.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: block accepts input this cycle.
- `A`, `Amax`, `Amin`  in  AW each: chosen, greedy and worst action.
- `R_hi`, `R_mid`, `R_lo`  in  DW each: signed reward levels.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `R`  out  DW: selected reward.
- `R_err`  out  1: `A`, `Amax` or `Amin` is ≥ NA.
- `episode_clr`  in  1: synchronous clear of statistics.
- `acc_sum`  out  SW: saturating signed sum of accepted `R`.
- `step_cnt`  out  CW: number of accepted output beats, saturating.
- `hit_cnt`  out  CW: number of accepted beats with `A==Amax`, saturating.

## Operation
- Selection is evaluated in the order below; the first match wins:
  - any index ≥ NA → `R`=0, `R_err`=1.
  - `A==Amax` → `R_hi`. This takes priority even when `Amax==Amin`.
  - `A==Amin` → `R_lo`.
  - otherwise → `R_mid`.
- Stage S1 registers `A`, `Amax`, `Amin` and the three levels on `in_valid && in_ready`.
- Stage S2 registers the selected `R` and `R_err`.
- All operands of a beat are captured together; there is no cross-beat mixing of `Amax`/`Amin`.
- Stall rules:
  - `adv2 = !out_valid || out_ready`.
  - `adv1 = !s1_valid || adv2`.
  - `in_ready = adv1`, which is a combinational path from `out_ready`.
- While stalled, S1 and S2 hold their data; `R` stays stable while `out_valid && !out_ready`.
- Statistics update only on `out_valid && out_ready`:
  - `acc_sum += sext(R)`, saturating at the SW signed max/min.
  - `step_cnt += 1`, saturating at all-ones.
  - `hit_cnt += 1` if the beat was a `R_hi` selection; saturating.
- Beats with `R_err`=1 are still counted in `step_cnt` and add 0 to `acc_sum`.
- `episode_clr` zeroes all three statistics next edge. It has priority over a simultaneous accepted beat, and that beat is dropped from the statistics.
- `episode_clr` does not flush the pipeline.

## Timing
- Reset (async assert, sync release), values while `rst`=0:
  - `out_valid`=0, `s1_valid`=0, `R`=0, `R_err`=0.
  - `acc_sum`=0, `step_cnt`=0, `hit_cnt`=0.
  - `in_ready`=1.
- Latency: an input accepted at edge n gives `out_valid`=1 after edge n+1, with no stall.
- Throughput: 1 beat/cycle when `out_ready`=1.
- Full: both stages valid and `out_ready`=0 → `in_ready`=0. No beat is lost or duplicated.
- Reset mid-operation discards all in-flight beats; nothing is emitted after release until new input.
- Statistics are visible the cycle after the accepting edge.

## Structure
- Package `rd_pkg` holds:
  - the `sel_e` enum {SEL_LO, SEL_MID, SEL_HI, SEL_ERR};
  - the function `rd_select(A, Amax, Amin, NA)` returning `sel_e`;
  - saturating add functions for signed and unsigned operands.
- One sub-module, `rd_stat_acc`, contains the saturating accumulator and the two counters, with `episode_clr` priority.
- The pipeline and selection logic live in the top module.

## Test plan
- NA=4, `R_hi`=10, `R_mid`=0, `R_lo`=-5, `out_ready`=1; beats (A,Amax,Amin) = (2,2,1), (1,2,1), (3,2,1), (0,0,0) → `R` = 10, -5, 0, 10 at 2-cycle latency; then `hit_cnt`=2, `step_cnt`=4, `acc_sum`=15.
- Backpressure: stream 6 beats, hold `out_ready`=0 for 4 cycles → `in_ready` drops after 2 accepts, `R` is stable, all 6 results arrive in order, no duplicates.
- Range error: NA=3, A=3 → `R`=0 and `R_err`=1; `step_cnt` increments and `acc_sum` is unchanged.
- Saturation: SW=DW=8, repeat `R_hi`=100 → `acc_sum` sticks at 127; repeat `R_lo`=-100 after clear → sticks at -128.
- `episode_clr` asserted in the same cycle as an accepted beat → all statistics read 0 next cycle; the pipeline output is still delivered.
- Assert `rst`=0 with 2 beats in flight → `out_valid`=0 immediately, statistics are 0, and no stale beat appears after release.

Source files
------------

// File: rtl/rd_pkg.sv
// Shared types and helpers for the reward decider pipeline.
// Saturating adders work on 64-bit containers; callers pass the live width.
package rd_pkg;

    typedef enum logic [1:0] {
        SEL_LO,
        SEL_MID,
        SEL_HI,
        SEL_ERR
    } sel_e;

    function automatic sel_e rd_select(
        input int unsigned a,
        input int unsigned amax,
        input int unsigned amin,
        input int unsigned na
    );
        sel_e s;
        if (a >= na || amax >= na || amin >= na) begin
            s = SEL_ERR;
        end else if (a == amax) begin
            s = SEL_HI;
        end else if (a == amin) begin
            s = SEL_LO;
        end else begin
            s = SEL_MID;
        end
        return s;
    endfunction

    function automatic logic signed [63:0] sat_add_s(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        s  = a + b;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (w - 1));
        if (s > mx) begin
            s = mx;
        end else if (s < mn) begin
            s = mn;
        end
        return s;
    endfunction

    function automatic logic [63:0] sat_add_u(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w
    );
        logic [63:0] s;
        logic [63:0] mx;
        s  = a + b;
        mx = (64'd1 << w) - 64'd1;
        return (s > mx) ? mx : s;
    endfunction

endpackage

// File: rtl/rd_stat_acc.sv
// Per-episode statistics: saturating reward sum, step and greedy-hit counts.
// A clear wins over a simultaneous accepted beat, which is then not counted.
module rd_stat_acc
    import rd_pkg::*;
#(
    parameter int DW = 32,
    parameter int SW = 40,
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          err,
    input  logic          hit,
    input  logic [DW-1:0] r,
    output logic [SW-1:0] acc_sum,
    output logic [CW-1:0] step_cnt,
    output logic [CW-1:0] hit_cnt
);

    logic [SW-1:0] acc_q, acc_d;
    logic [CW-1:0] step_q, step_d;
    logic [CW-1:0] hit_q, hit_d;
    logic signed [63:0] acc_x;
    logic signed [63:0] r_x;

    always_comb begin
        acc_x  = {{(64-SW){acc_q[SW-1]}}, acc_q};
        r_x    = err ? 64'sd0 : {{(64-DW){r[DW-1]}}, r};
        acc_d  = acc_q;
        step_d = step_q;
        hit_d  = hit_q;
        if (clr) begin
            acc_d  = '0;
            step_d = '0;
            hit_d  = '0;
        end else if (en) begin
            acc_d  = SW'(sat_add_s(acc_x, r_x, SW));
            step_d = CW'(sat_add_u(64'(step_q), 64'd1, CW));
            if (hit) begin
                hit_d = CW'(sat_add_u(64'(hit_q), 64'd1, CW));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            step_q <= '0;
            hit_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
            hit_q  <= hit_d;
        end
    end

    assign acc_sum  = acc_q;
    assign step_cnt = step_q;
    assign hit_cnt  = hit_q;

endmodule

// File: rtl/reward_decider_pipe.sv
// Q-learning reward decider: S1 captures a beat, S2 holds the chosen reward.
// in_ready is combinational from out_ready so a full pipe still streams.
module reward_decider_pipe
    import rd_pkg::*;
#(
    parameter int DW = 32,
    parameter int NA = 4,
    parameter int AW = $clog2(NA),
    parameter int SW = 40,
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] A,
    input  logic [AW-1:0] Amax,
    input  logic [AW-1:0] Amin,
    input  logic [DW-1:0] R_hi,
    input  logic [DW-1:0] R_mid,
    input  logic [DW-1:0] R_lo,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] R,
    output logic          R_err,
    input  logic          episode_clr,
    output logic [SW-1:0] acc_sum,
    output logic [CW-1:0] step_cnt,
    output logic [CW-1:0] hit_cnt
);

    logic          s1_valid_q, s1_valid_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] amax_q, amax_d;
    logic [AW-1:0] amin_q, amin_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] mid_q, mid_d;
    logic [DW-1:0] lo_q, lo_d;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] r_q, r_d;
    logic          err_q, err_d;
    logic          hit_q, hit_d;

    logic          adv1;
    logic          adv2;
    sel_e          sel;

    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        amax_d     = amax_q;
        amin_d     = amin_q;
        hi_d       = hi_q;
        mid_d      = mid_q;
        lo_d       = lo_q;
        if (adv1) begin
            s1_valid_d = in_valid;
        end
        if (adv1 && in_valid) begin
            a_d    = A;
            amax_d = Amax;
            amin_d = Amin;
            hi_d   = R_hi;
            mid_d  = R_mid;
            lo_d   = R_lo;
        end
    end

    always_comb begin
        sel         = rd_select(32'(a_q), 32'(amax_q), 32'(amin_q), NA);
        out_valid_d = out_valid_q;
        r_d         = r_q;
        err_d       = err_q;
        hit_d       = hit_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
        end
        if (adv2 && s1_valid_q) begin
            err_d = (sel == SEL_ERR);
            hit_d = (sel == SEL_HI);
            unique case (sel)
                SEL_HI:  r_d = hi_q;
                SEL_LO:  r_d = lo_q;
                SEL_MID: r_d = mid_q;
                default: r_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            amax_q      <= '0;
            amin_q      <= '0;
            hi_q        <= '0;
            mid_q       <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            err_q       <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            amax_q      <= amax_d;
            amin_q      <= amin_d;
            hi_q        <= hi_d;
            mid_q       <= mid_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            err_q       <= err_d;
            hit_q       <= hit_d;
        end
    end

    assign out_valid = out_valid_q;
    assign R         = r_q;
    assign R_err     = err_q;

    rd_stat_acc #(
        .DW(DW),
        .SW(SW),
        .CW(CW)
    ) u_stat (
        .clk     (clk),
        .rst     (rst),
        .clr     (episode_clr),
        .en      (out_valid_q && out_ready),
        .err     (err_q),
        .hit     (hit_q),
        .r       (r_q),
        .acc_sum (acc_sum),
        .step_cnt(step_cnt),
        .hit_cnt (hit_cnt)
    );

endmodule
